// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO family: output-mode constants
// and the sizing / pointer-wrap helpers used by the FIFO control logic.
package fifo_pkg;

  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  // Bits needed to hold an occupancy of 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Explicit wrap so depths that are not a power of two index correctly.
  function automatic int ptr_next(input int ptr, input int depth);
    return (ptr >= depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_ram_sp.sv
// WIDTH x DEPTH register array: one write port, one synchronous read port.
// A same-address read and write in one cycle returns the old word.
module fifo_ram_sp #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the storage array is deliberately not reset; occupancy tracking
  // guarantees no word is read before it is written, and an unreset array
  // maps onto plain flops or RAM without reset fan-out.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read register is reset so the FIFO output starts at zero.
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fifo_syn_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable
// almost-full/empty, sticky error flags and optional first-word-fall-through.
module fifo_syn_param
  import fifo_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = FIFO_STD
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr,
  input  logic                        rd,
  input  logic [WIDTH-1:0]            data,
  input  logic                        clr_err,
  output logic [WIDTH-1:0]            q,
  output logic                        full,
  output logic                        empty,
  output logic                        almost_full,
  output logic                        almost_empty,
  output logic [cnt_width(DEPTH)-1:0] count,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  logic             rd_acc;
  logic             wr_acc;
  logic             ram_we;
  logic             ram_re;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_nxt;
  logic [WIDTH-1:0] ram_q;

  // A full FIFO can still take a write when the same cycle frees a slot.
  assign rd_acc = rd & ~empty;
  assign wr_acc = wr & (~full | rd_acc);

  always_comb begin
    // NOTE: default assigned first so every path drives count_nxt; a missing
    // branch would otherwise infer a latch.
    count_nxt = count;
    if (wr_acc && !rd_acc)      count_nxt = count + CW'(1);
    else if (rd_acc && !wr_acc) count_nxt = count - CW'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      count        <= count_nxt;
      full         <= (count_nxt == DEPTH_C);
      empty        <= (count_nxt == '0);
      almost_full  <= (count_nxt >= AF_C);
      almost_empty <= (count_nxt <= AE_C);
      overflow     <= (overflow  & ~clr_err) | (wr & ~wr_acc);
      underflow    <= (underflow & ~clr_err) | (rd & ~rd_acc);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (ram_we) wr_ptr <= AW'(ptr_next(int'(wr_ptr), DEPTH));
      if (ram_re) rd_ptr <= AW'(ptr_next(int'(rd_ptr), DEPTH));
    end
  end

  fifo_ram_sp #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .waddr (wr_ptr),
    .wdata (data),
    .re    (ram_re),
    .raddr (rd_ptr),
    .rdata (ram_q)
  );

  generate
    if (FWFT == FIFO_FWFT) begin : g_fwft
      // The head word lives either in the RAM read register or, when it
      // arrived while nothing else was queued, in a bypass register. The RAM
      // then holds only the words behind the head.
      logic             one_left;
      logic             bypass;
      logic             sel_byp;
      logic [WIDTH-1:0] byp_q;

      assign one_left = (count == CW'(1));
      assign bypass   = wr_acc & (empty | (one_left & rd_acc));
      assign ram_we   = wr_acc & ~bypass;
      assign ram_re   = rd_acc & ~one_left;

      always_ff @(posedge clk) begin
        if (rst) begin
          byp_q   <= '0;
          sel_byp <= 1'b0;
        end else if (bypass) begin
          byp_q   <= data;
          sel_byp <= 1'b1;
        end else if (ram_re) begin
          sel_byp <= 1'b0;
        end
      end

      assign q = sel_byp ? byp_q : ram_q;
    end else begin : g_std
      assign ram_we = wr_acc;
      assign ram_re = rd_acc;
      assign q      = ram_q;
    end
  endgenerate

endmodule
